// File: rtl/rst_sequencer.sv
// Staged reset-release controller: releases NUM_STAGES reset domains in order, waiting for each ack.
// Optional macro RST_SEQ_MONITOR_EN adds a post-completion ack-drop monitor.
module rst_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_DLY  = 16,
    parameter int TIMEOUT    = 100,
    parameter int CNT_W      = 8,
    parameter int IDX_W      = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_STAGES-1:0] STAGE_ACK,
    output logic [NUM_STAGES-1:0] STAGE_RST_N,
    output logic                  SEQ_DONE,
    output logic                  SEQ_ERR,
    output logic [IDX_W-1:0]      ERR_STAGE
);

    typedef enum logic [1:0] {
        S_DELAY    = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_DONE     = 2'd2,
        S_ERROR    = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);
    localparam int               IDX_REQ  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    generate
        if (NUM_STAGES < 1) begin : g_bad_stages
            $error("rst_sequencer: NUM_STAGES must be at least 1");
        end
        if (STAGE_DLY < 1) begin : g_bad_dly
            $error("rst_sequencer: STAGE_DLY must be at least 1");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("rst_sequencer: TIMEOUT must be at least 1");
        end
        if ((STAGE_DLY - 1) >= (2 ** CNT_W) || (TIMEOUT - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
            $error("rst_sequencer: CNT_W too narrow for STAGE_DLY/TIMEOUT");
        end
        if (IDX_W != IDX_REQ) begin : g_bad_idx_w
            $error("rst_sequencer: IDX_W must equal clog2(NUM_STAGES), minimum 1");
        end
    endgenerate

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]   rst_n_q, rst_n_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        err_stage_q, err_stage_d;
    logic                    ack_cur;

    assign ack_cur = STAGE_ACK[idx_q];

`ifdef RST_SEQ_MONITOR_EN
    logic [IDX_W-1:0] drop_idx;

    // Scan from the top so the lowest dropped stage is the one that sticks.
    always_comb begin
        drop_idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!STAGE_ACK[i]) drop_idx = IDX_W'(i);
        end
    end
`endif

    // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rst_n_d     = rst_n_q;
        done_d      = done_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;

        case (state_q)
            S_DELAY: begin
                if (cnt_q == DLY_LAST) begin
                    rst_n_d[idx_q] = 1'b1;
                    cnt_d          = '0;
                    state_d        = S_WAIT_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_ACK: begin
                // An ack arriving on the timeout edge is still honoured.
                if (ack_cur) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                        state_d = S_DELAY;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d        = S_ERROR;
                    err_d          = 1'b1;
                    err_stage_d    = idx_q;
                    rst_n_d[idx_q] = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
`ifdef RST_SEQ_MONITOR_EN
                if (!(&STAGE_ACK)) begin
                    err_d       = 1'b1;
                    err_stage_d = drop_idx;
                    state_d     = S_ERROR;
                end
`endif
            end

            S_ERROR: begin
            end
        endcase
    end

    // NOTE: reset here is synchronous and active-high because the input is already synchronized upstream.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_DELAY;
            idx_q       <= '0;
            cnt_q       <= '0;
            rst_n_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rst_n_q     <= rst_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
        end
    end

    assign STAGE_RST_N = rst_n_q;
    assign SEQ_DONE    = done_q;
    assign SEQ_ERR     = err_q;
    assign ERR_STAGE   = err_stage_q;

endmodule
